// File: rtl/hpdmc_burst_seq.sv
// hpdmc_burst_seq: data-path sequencer in front of the DDR I/O block.
// Stages one write burst and times op_write/op_read and read-FIFO unload.
module hpdmc_burst_seq #(
  parameter int CL      = 2,
  parameter int WL      = 1,
  parameter int R_DRAIN = 2,
  parameter int TURN    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic        cmd_write,
  output logic        cmd_ready,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_dat,
  input  logic [7:0]  wr_mask,
  output logic        wr_loaded,
  output logic        rd_valid,
  output logic [63:0] rd_dat,
  output logic        op_write,
  output logic        op_read,
  output logic        buffer_w_nextburst,
  output logic        buffer_w_next,
  output logic [7:0]  buffer_w_mask,
  output logic [63:0] buffer_w_dat,
  output logic        buffer_r_nextburst,
  output logic        buffer_r_next,
  input  logic [63:0] buffer_r_dat
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_WAIT,
    S_W_DRIVE,
    S_R_WAIT,
    S_R_READ,
    S_R_DRAIN,
    S_R_NEXT,
    S_R_DELIVER,
    S_GAP
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] wcnt;
  logic       wbusy;
  logic       wtake;
  logic       wclr;
  logic       accept;

  assign wbusy     = (state == S_W_WAIT) || (state == S_W_DRIVE);
  assign wr_loaded = (wcnt == 3'd4);
  assign wr_ready  = ~rst & ~wbusy & (wcnt < 3'd4);
  assign wtake     = wr_valid & wr_ready;
  assign wclr      = (state == S_W_DRIVE) && (cnt == 4'd0);

  assign cmd_ready = ~rst & (state == S_IDLE)
                   & (~cmd_write | wr_loaded);
  assign accept    = cmd_valid & cmd_ready;

  assign buffer_w_nextburst = wtake & (wcnt == 3'd0);
  assign buffer_w_next      = wtake & (wcnt != 3'd0);
  assign buffer_w_mask      = wr_mask;
  assign buffer_w_dat       = wr_dat;
  assign rd_dat             = buffer_r_dat;

  // Staged write word count; emptied once the burst has gone out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 3'd0;
    end else if (wclr) begin
      wcnt <= 3'd0;
    end else if (wtake) begin
      wcnt <= wcnt + 3'd1;
    end
  end

  // Burst sequencer with registered DDR strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      cnt                <= 4'd0;
      op_write           <= 1'b0;
      op_read            <= 1'b0;
      rd_valid           <= 1'b0;
      buffer_r_nextburst <= 1'b0;
      buffer_r_next      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && cmd_write) begin
            if (WL == 1) begin
              state    <= S_W_DRIVE;
              op_write <= 1'b1;
              cnt      <= 4'd3;
            end else begin
              state <= S_W_WAIT;
              cnt   <= 4'(WL - 2);
            end
          end else if (accept) begin
            if (CL == 1) begin
              state   <= S_R_READ;
              op_read <= 1'b1;
              cnt     <= 4'd3;
            end else begin
              state <= S_R_WAIT;
              cnt   <= 4'(CL - 2);
            end
          end
        end
        S_W_WAIT: begin
          if (cnt == 4'd0) begin
            state    <= S_W_DRIVE;
            op_write <= 1'b1;
            cnt      <= 4'd3;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_W_DRIVE: begin
          if (cnt == 4'd0) begin
            op_write <= 1'b0;
            if (TURN == 0) begin
              state <= S_IDLE;
            end else begin
              state <= S_GAP;
              cnt   <= 4'(TURN - 1);
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_R_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= S_R_READ;
            op_read <= 1'b1;
            cnt     <= 4'd3;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_R_READ: begin
          if (cnt == 4'd0) begin
            op_read <= 1'b0;
            state   <= S_R_DRAIN;
            cnt     <= 4'(R_DRAIN - 1);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_R_DRAIN: begin
          if (cnt == 4'd0) begin
            state              <= S_R_NEXT;
            buffer_r_nextburst <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_R_NEXT: begin
          state              <= S_R_DELIVER;
          buffer_r_nextburst <= 1'b0;
          rd_valid           <= 1'b1;
          buffer_r_next      <= 1'b1;
          cnt                <= 4'd3;
        end
        S_R_DELIVER: begin
          if (cnt == 4'd1) begin
            buffer_r_next <= 1'b0;
          end
          if (cnt == 4'd0) begin
            rd_valid <= 1'b0;
            if (TURN == 0) begin
              state <= S_IDLE;
            end else begin
              state <= S_GAP;
              cnt   <= 4'(TURN - 1);
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_GAP: begin
          if (cnt == 4'd0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdmc_burst_seq.sv
// tb_hpdmc_burst_seq: directed stimulus, cycle-schedule model
// and literal timing checks for hpdmc_burst_seq.
module tb_hpdmc_burst_seq;

  localparam int CL      = 2;
  localparam int WL      = 1;
  localparam int R_DRAIN = 2;
  localparam int TURN    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic        cmd_ready;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_dat = 64'd0;
  logic [7:0]  wr_mask = 8'd0;
  logic        wr_loaded;
  logic        rd_valid;
  logic [63:0] rd_dat;
  logic        op_write;
  logic        op_read;
  logic        buffer_w_nextburst;
  logic        buffer_w_next;
  logic [7:0]  buffer_w_mask;
  logic [63:0] buffer_w_dat;
  logic        buffer_r_nextburst;
  logic        buffer_r_next;
  logic [63:0] buffer_r_dat;

  hpdmc_burst_seq #(
    .CL(CL), .WL(WL), .R_DRAIN(R_DRAIN), .TURN(TURN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_write(cmd_write),
    .cmd_ready(cmd_ready),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_dat(wr_dat),
    .wr_mask(wr_mask),
    .wr_loaded(wr_loaded),
    .rd_valid(rd_valid),
    .rd_dat(rd_dat),
    .op_write(op_write),
    .op_read(op_read),
    .buffer_w_nextburst(buffer_w_nextburst),
    .buffer_w_next(buffer_w_next),
    .buffer_w_mask(buffer_w_mask),
    .buffer_w_dat(buffer_w_dat),
    .buffer_r_nextburst(buffer_r_nextburst),
    .buffer_r_next(buffer_r_next),
    .buffer_r_dat(buffer_r_dat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] rmem [4];
  logic [1:0]  ridx = 2'd0;

  // Read FIFO responder: rewind on nextburst, advance on next.
  always @(posedge clk) begin
    if (buffer_r_nextburst) ridx <= 2'd0;
    else if (buffer_r_next) ridx <= ridx + 2'd1;
  end
  assign buffer_r_dat = rmem[ridx];

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  // Schedule model: each accepted command fixes a cycle window
  int   w_t0 = -1000;
  int   r_t0 = -1000;
  int   idle_from = 0;
  int   wcnt_m = 0;
  int   nb;
  logic e_cr, e_wr, e_take;

  always @(negedge clk) begin
    if (rst) begin
      w_t0 = -1000;
      r_t0 = -1000;
      wcnt_m = 0;
      idle_from = cyc;
      chk("m_rst_cr", cmd_ready, 0);
      chk("m_rst_wr", wr_ready, 0);
      chk("m_rst_opw", op_write, 0);
      chk("m_rst_opr", op_read, 0);
      chk("m_rst_rv", rd_valid, 0);
      chk("m_rst_rnb", buffer_r_nextburst, 0);
      chk("m_rst_rn", buffer_r_next, 0);
      chk("m_rst_wl", wr_loaded, 0);
    end else begin
      nb = r_t0 + CL + 4 + R_DRAIN;
      e_cr = (cyc >= idle_from) && (!cmd_write || wcnt_m == 4);
      e_wr = (wcnt_m < 4) &&
             !(cyc >= w_t0 + 1 && cyc <= w_t0 + WL + 3);
      e_take = wr_valid && e_wr;
      chk("m_cmd_ready", cmd_ready, e_cr);
      chk("m_wr_ready", wr_ready, e_wr);
      chk("m_wr_loaded", wr_loaded, wcnt_m == 4);
      chk("m_w_nb", buffer_w_nextburst, e_take && wcnt_m == 0);
      chk("m_w_next", buffer_w_next, e_take && wcnt_m != 0);
      chk("m_w_dat", buffer_w_dat, wr_dat);
      chk("m_w_mask", buffer_w_mask, wr_mask);
      chk("m_op_write", op_write,
          cyc >= w_t0 + WL && cyc <= w_t0 + WL + 3);
      chk("m_op_read", op_read,
          cyc >= r_t0 + CL && cyc <= r_t0 + CL + 3);
      chk("m_r_nb", buffer_r_nextburst, cyc == nb);
      chk("m_rd_valid", rd_valid, cyc > nb && cyc <= nb + 4);
      chk("m_r_next", buffer_r_next, cyc > nb && cyc <= nb + 3);
      if (cyc > nb && cyc <= nb + 4)
        chk("m_rd_dat", rd_dat, rmem[cyc - nb - 1]);
      if (cmd_valid && e_cr) begin
        if (cmd_write) begin
          w_t0 = cyc;
          idle_from = cyc + WL + 4 + TURN;
        end else begin
          r_t0 = cyc;
          idle_from = cyc + CL + R_DRAIN + 9 + TURN;
        end
      end
      if (e_take) wcnt_m++;
      if (cyc == w_t0 + WL + 3) wcnt_m = 0;
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int seq = 0;

  task automatic stage(input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_dat = 64'hD00D_0000_0000_0000 + 64'(seq);
      wr_mask = 8'(seq * 8'h11);
      seq++;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  logic [7:0]  t1m [4];
  logic [3:0]  nbp = 4'b0001;
  logic [3:0]  nxp = 4'b1110;
  logic [7:0]  opw_pat = 8'b0001_1110;
  logic [15:0] opr_pat = 16'h003C;
  logic [15:0] rnb_pat = 16'h0100;
  logic [15:0] rv_pat = 16'h1E00;
  logic [15:0] rn_pat = 16'h0E00;
  logic [7:0]  wrp = 8'b0110_0000;

  initial begin
    rmem[0] = 64'h0123_4567_89AB_CDEF;
    rmem[1] = 64'hFEDC_BA98_7654_3210;
    rmem[2] = 64'hDEAD_BEEF_CAFE_F00D;
    rmem[3] = 64'h5555_AAAA_0F0F_F0F0;
    t1m[0] = 8'h00;
    t1m[1] = 8'h0F;
    t1m[2] = 8'hF0;
    t1m[3] = 8'hFF;

    // reset
    tick();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    tick();
    rst = 1'b0;
    tick();

    // T1: stage four words
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_dat = 64'hA5A5_0000_0000_0000 + 64'(i);
      wr_mask = t1m[i];
      @(negedge clk);
      chk("t1_nextburst", buffer_w_nextburst, nbp[i]);
      chk("t1_next", buffer_w_next, nxp[i]);
      chk("t1_mask", buffer_w_mask, t1m[i]);
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t1_loaded", wr_loaded, 1);
    chk("t1_full_rdy", wr_ready, 0);
    tick();

    // T2: write burst
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    @(negedge clk);
    chk("t2_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("t2_op_write", op_write, opw_pat[k]);
      if (k == 5) chk("t2_unloaded", wr_loaded, 0);
      if (k == 5 || k == 6) chk("t2_gap", cmd_ready, 0);
      if (k == 7) chk("t2_idle", cmd_ready, 1);
      tick();
    end

    // T3: read burst
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("t3_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("t3_op_read", op_read, opr_pat[k]);
      chk("t3_r_nb", buffer_r_nextburst, rnb_pat[k]);
      chk("t3_rd_valid", rd_valid, rv_pat[k]);
      chk("t3_r_next", buffer_r_next, rn_pat[k]);
      if (k >= 9 && k <= 12) chk("t3_rd_dat", rd_dat, rmem[k - 9]);
      if (k == 15) chk("t3_idle", cmd_ready, 1);
      tick();
    end

    // T4: write command stalls until staging completes
    stage(2);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    @(negedge clk);
    chk("t4_stall0", cmd_ready, 0);
    tick();
    wr_valid = 1'b1;
    wr_dat = 64'h4444_0000_0000_0003;
    @(negedge clk);
    chk("t4_stall2", cmd_ready, 0);
    tick();
    wr_dat = 64'h4444_0000_0000_0004;
    @(negedge clk);
    chk("t4_stall3", cmd_ready, 0);
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t4_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    repeat (6) tick();

    // T5: stage during read delivery, then back-to-back write
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("t5_rd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    repeat (8) tick();
    stage(4);
    repeat (2) tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    wr_valid = 1'b1;
    wr_dat = 64'h5555_0000_0000_0001;
    @(negedge clk);
    chk("t5_wr_accept", cmd_ready, 1);
    chk("t5_full_hold", wr_ready, 0);
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t5_wr_ready", wr_ready, wrp[k]);
      tick();
      wr_dat = wr_dat + 64'd1;
    end
    wr_valid = 1'b0;

    // T6: reset in the middle of a read burst
    stage(2);
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("t6_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_op_read", op_read, 0);
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_loaded", wr_loaded, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle", cmd_ready, 1);
    chk("t6_loaded2", wr_loaded, 0);
    chk("t6_wr_ready", wr_ready, 1);
    tick();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
